ma_stage: RTL and testbench
===========================

Name: ma_stage

Overview:
Memory-access stage of the rv32 5-stage pipeline. It sits between the EX/MA pipeline register and the MA/WB pipeline register.
- Performs loads and stores over a req/ack data-memory port.
- Formats load data and produces the write-back value.
- Forwards inst, pc and branch flags to MA/WB.
- Stalls upstream stages while a memory access is outstanding.

Parameters:
TIMEOUT_CYCLES, 64, cycles in REQ without dmem_ack before the access is aborted as a bus error
NOP_INST, 32'h00000013, instruction substituted for a killed access (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
ex_valid  in  1  EX/MA holds a valid instruction
ex_inst  in  32  instruction from EX/MA
ex_pc  in  32  pc from EX/MA
ex_alu_result  in  32  ALU result / effective address
ex_rs2_data  in  32  store data
ex_branch_neq / ex_branch_lt / ex_branch_rs2_eq_0  in  1 each  branch flags from EX
ma_inst  out  32  to MA/WB new_inst
ma_pc  out  32  to MA/WB new_pc
ma_wbdata  out  32  to MA/WB new_wbdata
ma_branch_neq / ma_branch_lt / ma_branch_rs2_eq_0  out  1 each  to MA/WB, pass-through
ma_stall  out  1  freeze IF/ID/EX and hold EX/MA
ma_misaligned  out  1  one-cycle pulse, misaligned access killed
ma_bus_err  out  1  sticky, set on timeout
dmem_req  out  1  access request
dmem_we  out  1  1 = store
dmem_addr  out  32  word address, {ex_alu_result[31:2],2'b00}
dmem_wdata  out  32  lane-replicated store data
dmem_wstrb  out  4  byte enables, stores only; 0 for loads
dmem_ack  in  1  access complete; rdata valid the same cycle for loads
dmem_rdata  in  32  load word

Behaviour:
- Memory op: ex_valid=1 and opcode ex_inst[6:0] is 0000011 (load) or 0100011 (store). All other instructions are non-memory.
- Non-memory op or ex_valid=0: combinational pass-through. ma_wbdata=ex_alu_result, ma_stall=0, dmem_req=0, zero added latency.
- Branch flags, ma_pc and ma_inst always pass through unchanged, except for a killed access.
- Misalignment checked combinationally from ex_alu_result[1:0] and funct3:
  - LH/LHU/SH with addr[0]=1 is misaligned.
  - LW/SW with addr[1:0]!=0 is misaligned.
  - On misalignment: no dmem_req, ma_misaligned=1, ma_inst=NOP_INST, ma_wbdata=0, ma_stall=0.
- FSM states IDLE, REQ, DONE. Reset state is IDLE.
  - IDLE: aligned memory op present -> dmem_req=1 combinationally, ma_stall=1.
    - dmem_ack=1 the same cycle -> capture dmem_rdata, go DONE.
    - else -> REQ.
  - REQ: dmem_req=1. dmem_addr/we/wdata/wstrb are held stable, since EX/MA is frozen by ma_stall. ma_stall=1.
    - dmem_ack -> capture rdata, clear timeout counter, go DONE.
    - Counter reaches TIMEOUT_CYCLES-1 without ack -> set ma_bus_err, go DONE with a kill flag.
  - DONE: dmem_req=0, ma_stall=0.
    - ma_wbdata = formatted captured data (0 for stores).
    - If killed: ma_inst=NOP_INST, ma_wbdata=0.
    - Next edge -> IDLE, which lets the next instruction enter. Back-to-back memory ops therefore cost at least 2 cycles each.
- Load formatting uses byte lane addr[1:0], or halfword lane addr[1]:
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW returns the word.
- Store data and strobes:
  - SB: wdata={4{rs2[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - SH: wdata={2{rs2[15:0]}}, wstrb=addr[1]?1100:0011.
  - SW: wstrb=1111.
- Unsupported funct3 on a load/store opcode is treated as a non-memory op: pass-through, no access.
- dmem_ack outside REQ, or in IDLE without a request, is ignored.
- Reset, including mid-access:
  - State goes to IDLE; counter, rdata register and ma_bus_err clear to 0.
  - While resetn=0: dmem_req=0, ma_stall=0, ma_misaligned=0, ma_inst=0, ma_pc=0, ma_wbdata=0, all branch-flag outputs 0.
  - An aborted access is not replayed by this block.

Test Plan:
- ADD with ex_alu_result=0x1234 -> ma_wbdata=0x1234 same cycle, ma_stall=0, dmem_req=0.
- LB at addr 0x103, dmem_rdata=0x80FF_FF00, ack after 3 cycles -> dmem_addr=0x100, ma_stall high 4 cycles, then ma_wbdata=0xFFFFFF80 for one cycle.
- SH at addr 0x202, rs2=0xABCD1234 -> dmem_wdata=0x12341234, wstrb=1100, we=1; zero-wait ack -> stall exactly 1 cycle.
- LW at addr 0x105 -> no dmem_req, ma_misaligned pulse, ma_inst=0x00000013, ma_wbdata=0.
- LW with dmem_ack never asserted -> after 64 cycles ma_bus_err=1 (sticky), ma_inst=NOP, stall released; the next ADD passes through.
- resetn low during REQ -> dmem_req, ma_stall and ma_bus_err 0 immediately; after release the FSM is in IDLE.

Source files
------------

// File: rtl/ma_stage.sv
// ma_stage: rv32 memory-access stage with a req/ack data port, load formatting and a timeout abort
module ma_stage #(
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] NOP_INST       = 32'h00000013
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_valid,
  input  logic [31:0] ex_inst,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_rs2_data,
  input  logic        ex_branch_neq,
  input  logic        ex_branch_lt,
  input  logic        ex_branch_rs2_eq_0,
  output logic [31:0] ma_inst,
  output logic [31:0] ma_pc,
  output logic [31:0] ma_wbdata,
  output logic        ma_branch_neq,
  output logic        ma_branch_lt,
  output logic        ma_branch_rs2_eq_0,
  output logic        ma_stall,
  output logic        ma_misaligned,
  output logic        ma_bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2;
  logic [1:0]    state, state_nxt;
  logic [CW-1:0] cnt;
  logic [31:0]   rdata_q, ld_data;
  logic [15:0]   half;
  logic [7:0]    lane_b;
  logic [2:0]    f3;
  logic is_load, is_store, mem_op, misal, go, busy, timeout, kill, kill_q, bus_err_q;
  assign f3       = ex_inst[14:12];
  assign is_load  = ex_inst[6:0] == 7'b0000011 && f3 != 3'b011 && f3[2:1] != 2'b11;
  assign is_store = ex_inst[6:0] == 7'b0100011 && !f3[2] && f3[1:0] != 2'b11;
  assign mem_op   = ex_valid && (is_load || is_store);
  assign misal    = (f3[1:0] == 2'b01 && ex_alu_result[0]) || (f3[1:0] == 2'b10 && ex_alu_result[1:0] != 2'b00);
  assign go       = mem_op && !misal;
  assign busy     = (state == IDLE && go) || state == REQ;
  assign timeout  = state == REQ && !dmem_ack && cnt == CW'(TIMEOUT_CYCLES - 1);
  assign kill     = ma_misaligned || (state == DONE && kill_q);
  always_comb
    state_nxt = state == IDLE ? (go ? (dmem_ack ? DONE : REQ) : IDLE) :
                state == REQ  ? ((dmem_ack || timeout) ? DONE : REQ) : IDLE;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      rdata_q   <= '0;
      kill_q    <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= (state == REQ && !dmem_ack && !timeout) ? cnt + CW'(1) : '0;
      rdata_q   <= (busy && dmem_ack) ? dmem_rdata : rdata_q;
      kill_q    <= timeout;
      bus_err_q <= bus_err_q | timeout;
    end
  // EX/MA is frozen until DONE, so the captured word is formatted with the still-held address and funct3
  assign lane_b = 8'(rdata_q >> {ex_alu_result[1:0], 3'b000});
  assign half   = ex_alu_result[1] ? rdata_q[31:16] : rdata_q[15:0];
  always_comb
    ld_data = f3 == 3'b000 ? {{24{lane_b[7]}}, lane_b} :
              f3 == 3'b001 ? {{16{half[15]}}, half} :
              f3 == 3'b100 ? {24'h0, lane_b} :
              f3 == 3'b101 ? {16'h0, half} : rdata_q;
  assign dmem_req           = resetn && busy;
  assign ma_stall           = resetn && busy;
  assign ma_misaligned      = resetn && state == IDLE && mem_op && misal;
  assign ma_bus_err         = bus_err_q;
  assign ma_inst            = !resetn ? '0 : kill ? NOP_INST : ex_inst;
  assign ma_pc              = resetn ? ex_pc : '0;
  assign ma_wbdata          = (!resetn || kill) ? '0 : state == DONE ? (is_store ? '0 : ld_data) : ex_alu_result;
  assign ma_branch_neq      = resetn && ex_branch_neq;
  assign ma_branch_lt       = resetn && ex_branch_lt;
  assign ma_branch_rs2_eq_0 = resetn && ex_branch_rs2_eq_0;
  assign dmem_we            = ex_valid && is_store;
  assign dmem_addr          = {ex_alu_result[31:2], 2'b00};
  assign dmem_wdata         = f3[1:0] == 2'b00 ? {4{ex_rs2_data[7:0]}} :
                              f3[1:0] == 2'b01 ? {2{ex_rs2_data[15:0]}} : ex_rs2_data;
  assign dmem_wstrb         = !dmem_we ? 4'b0000 :
                              f3[1:0] == 2'b00 ? 4'b0001 << ex_alu_result[1:0] :
                              f3[1:0] == 2'b01 ? (ex_alu_result[1] ? 4'b1100 : 4'b0011) : 4'b1111;
endmodule

// File: tb/tb_ma_stage.sv
// tb_ma_stage: directed and randomized checks of ma_stage against a behavioural memory-stage model
module tb_ma_stage;
  logic        clk = 1'b0, resetn;
  logic        ex_valid, ex_branch_neq, ex_branch_lt, ex_branch_rs2_eq_0;
  logic [31:0] ex_inst, ex_pc, ex_alu_result, ex_rs2_data;
  logic [31:0] ma_inst, ma_pc, ma_wbdata;
  logic        ma_branch_neq, ma_branch_lt, ma_branch_rs2_eq_0;
  logic        ma_stall, ma_misaligned, ma_bus_err;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  int n_chk = 0, n_fail = 0;
  logic [31:0] exp_pc;
  logic [2:0]  exp_fl;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [6:0]  OP_LD = 7'h03, OP_ST = 7'h23;

  ma_stage dut (
    .clk(clk), .resetn(resetn), .ex_valid(ex_valid), .ex_inst(ex_inst), .ex_pc(ex_pc),
    .ex_alu_result(ex_alu_result), .ex_rs2_data(ex_rs2_data), .ex_branch_neq(ex_branch_neq),
    .ex_branch_lt(ex_branch_lt), .ex_branch_rs2_eq_0(ex_branch_rs2_eq_0), .ma_inst(ma_inst),
    .ma_pc(ma_pc), .ma_wbdata(ma_wbdata), .ma_branch_neq(ma_branch_neq), .ma_branch_lt(ma_branch_lt),
    .ma_branch_rs2_eq_0(ma_branch_rs2_eq_0), .ma_stall(ma_stall), .ma_misaligned(ma_misaligned),
    .ma_bus_err(ma_bus_err), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3);
    logic [31:0] r;
    r = $urandom;
    return {r[31:15], f3, r[11:7], opc};
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    int unsigned lane, b, h;
    lane = a % 4;
    b = (w >> (8 * lane)) & 255;
    h = (w >> (16 * (lane / 2))) & 65535;
    case (f3)
      3'd0:    return b >= 128 ? b - 256 : b;
      3'd1:    return h >= 32768 ? h - 65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    int unsigned sz;
    sz = f3 % 4;
    return sz == 0 ? (rs2 & 255) * 32'h01010101 : sz == 1 ? (rs2 & 65535) * 32'h00010001 : rs2;
  endfunction

  function automatic logic [3:0] exp_wstrb(input logic [2:0] f3, input logic [31:0] a);
    int unsigned bytes;
    bytes = 1 << (f3 % 4);
    return 4'(((1 << bytes) - 1) << (a % 4));
  endfunction

  function automatic bit is_misal(input logic [2:0] f3, input logic [31:0] a);
    return (a % (1 << (f3 % 4))) != 0;
  endfunction

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] addr, input logic [31:0] rs2);
    ex_valid = v;
    ex_inst = inst;
    ex_alu_result = addr;
    ex_rs2_data = rs2;
    exp_pc = $urandom;
    exp_fl = 3'($urandom);
    ex_pc = exp_pc;
    {ex_branch_neq, ex_branch_lt, ex_branch_rs2_eq_0} = exp_fl;
  endtask

  task automatic chk_pass(input string tag);
    chk({tag, "_pc"}, ma_pc, exp_pc);
    chk({tag, "_flags"}, 32'({ma_branch_neq, ma_branch_lt, ma_branch_rs2_eq_0}), 32'(exp_fl));
  endtask

  task automatic passthru(input logic v, input logic [31:0] inst, input logic [31:0] alu);
    drive(v, inst, alu, $urandom);
    dmem_ack = 1'($urandom);
    #1;
    chk("pt_wbdata", ma_wbdata, alu);
    chk("pt_stall", 32'(ma_stall), 0);
    chk("pt_req", 32'(dmem_req), 0);
    chk("pt_misal", 32'(ma_misaligned), 0);
    chk("pt_inst", ma_inst, inst);
    chk_pass("pt");
    @(posedge clk); #1;
    dmem_ack = 1'b0;
  endtask

  task automatic misal_op(input logic [31:0] inst, input logic [31:0] addr);
    drive(1'b1, inst, addr, $urandom);
    #1;
    chk("mis_req", 32'(dmem_req), 0);
    chk("mis_pulse", 32'(ma_misaligned), 1);
    chk("mis_inst", ma_inst, NOP);
    chk("mis_wbdata", ma_wbdata, 0);
    chk("mis_stall", 32'(ma_stall), 0);
    chk_pass("mis");
    @(posedge clk); #1;
  endtask

  task automatic mem_op(input logic [31:0] inst, input logic [31:0] addr, input logic [31:0] rs2,
                        input logic [31:0] rdat, input int delay);
    logic [2:0] f3;
    logic st;
    f3 = inst[14:12];
    st = inst[6:0] == OP_ST;
    drive(1'b1, inst, addr, rs2);
    for (int c = 0; c <= delay; c++) begin
      dmem_ack = (c == delay);
      dmem_rdata = (c == delay) ? rdat : $urandom;
      #1;
      chk("mem_stall", 32'(ma_stall), 1);
      chk("mem_req", 32'(dmem_req), 1);
      chk("mem_addr", dmem_addr, addr & ~32'h3);
      chk("mem_we", 32'(dmem_we), 32'(st));
      chk("mem_wstrb", 32'(dmem_wstrb), st ? 32'(exp_wstrb(f3, addr)) : 0);
      if (st) chk("mem_wdata", dmem_wdata, exp_wdata(f3, rs2));
      @(posedge clk); #1;
    end
    dmem_ack = 1'b0;
    dmem_rdata = $urandom;
    #1;
    chk("done_stall", 32'(ma_stall), 0);
    chk("done_req", 32'(dmem_req), 0);
    chk("done_wbdata", ma_wbdata, st ? 0 : exp_load(f3, addr, rdat));
    chk("done_inst", ma_inst, inst);
    chk_pass("done");
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] a, inst;
    logic [2:0]  f3;
    int          k, cyc;
    resetn = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    drive(1'b1, mk(OP_LD, 3'd2), 32'h40, 32'h0);
    ex_pc = 32'hDEAD_BEEF;
    {ex_branch_neq, ex_branch_lt, ex_branch_rs2_eq_0} = 3'b111;
    #1;
    chk("rst_req", 32'(dmem_req), 0);
    chk("rst_stall", 32'(ma_stall), 0);
    chk("rst_inst", ma_inst, 0);
    chk("rst_pc", ma_pc, 0);
    chk("rst_wbdata", ma_wbdata, 0);
    chk("rst_flags", 32'({ma_branch_neq, ma_branch_lt, ma_branch_rs2_eq_0}), 0);
    chk("rst_buserr", 32'(ma_bus_err), 0);
    chk("rst_misal", 32'(ma_misaligned), 0);
    ex_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    passthru(1'b1, 32'h002081B3, 32'h1234);
    mem_op(mk(OP_LD, 3'd0), 32'h103, 32'h0, 32'h80FF_FF00, 3);
    mem_op(mk(OP_ST, 3'd1), 32'h202, 32'hABCD_1234, 32'h0, 0);
    misal_op(mk(OP_LD, 3'd2), 32'h105);
    passthru(1'b1, 32'h002081B3, 32'h55AA);
    drive(1'b1, mk(OP_LD, 3'd2), 32'h80, 32'h0);
    #1;
    chk("to_buserr_before", 32'(ma_bus_err), 0);
    cyc = 0;
    while (ma_stall === 1'b1 && cyc < 200) begin
      cyc++;
      @(posedge clk); #1;
    end
    chk("to_stall_cycles", 32'(cyc), 65);
    chk("to_buserr", 32'(ma_bus_err), 1);
    chk("to_inst", ma_inst, NOP);
    chk("to_wbdata", ma_wbdata, 0);
    chk("to_req", 32'(dmem_req), 0);
    @(posedge clk); #1;
    passthru(1'b1, 32'h002081B3, 32'h0BAD_F00D);
    chk("to_buserr_sticky", 32'(ma_bus_err), 1);
    drive(1'b1, mk(OP_LD, 3'd2), 32'h300, 32'h0);
    @(posedge clk); #1;
    chk("rq_req", 32'(dmem_req), 1);
    resetn = 1'b0;
    #1;
    chk("rq_rst_req", 32'(dmem_req), 0);
    chk("rq_rst_stall", 32'(ma_stall), 0);
    chk("rq_rst_buserr", 32'(ma_bus_err), 0);
    chk("rq_rst_inst", ma_inst, 0);
    ex_valid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    passthru(1'b0, mk(OP_LD, 3'd2), 32'h300);
    mem_op(mk(OP_ST, 3'd2), 32'h404, 32'h1357_9BDF, 32'h0, 0);
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 4);
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      case (k)
        0: passthru(1'b1, 32'h00000033 | ($urandom & 32'hFFFF_FF80), a);
        1: passthru(1'b0, mk($urandom_range(0, 1) == 1 ? OP_LD : OP_ST, 3'($urandom)), a);
        2: begin
          f3 = 3'($urandom_range(0, 4));
          f3 = f3 == 3'd3 ? 3'd5 : f3;
          inst = mk(OP_LD, f3);
          if (is_misal(f3, a)) misal_op(inst, a);
          else mem_op(inst, a, $urandom, $urandom, $urandom_range(0, 4));
        end
        3: begin
          f3 = 3'($urandom_range(0, 2));
          inst = mk(OP_ST, f3);
          if (is_misal(f3, a)) misal_op(inst, a);
          else mem_op(inst, a, $urandom, $urandom, $urandom_range(0, 4));
        end
        default: begin
          inst = $urandom_range(0, 1) == 1 ? mk(OP_LD, 3'($urandom_range(6, 7))) : mk(OP_ST, 3'($urandom_range(3, 7)));
          passthru(1'b1, inst, a);
        end
      endcase
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
